// File: rtl/subsystem_fetch.sv
// subsystem_fetch: single-outstanding instruction fetch feeding decode through a 2-entry queue
module subsystem_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    output logic              pc_enable,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FULL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;
    logic [1:0]        count_q, count_d;
    logic              rd_q;
    logic [DATA_W-1:0] data_q [2];
    logic [ADDR_W-1:0] pcs_q [2];
    logic              push, pop, wr_idx;

    assign inst_valid = count_q != 2'd0;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign push       = state_q == WAIT && imem_ack && !redirect;
    assign pc_enable  = redirect || (state_q == WAIT && imem_ack);
    assign count_d    = redirect ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    assign wr_idx     = rd_q ^ count_q[0];
    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst       = data_q[rd_q];
    assign inst_pc    = pcs_q[rd_q];

    // Next fetch state; a stale request left in flight by a redirect is always drained first
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = ISSUE;
            ISSUE:   state_d = redirect ? ISSUE : WAIT;
            WAIT:    state_d = imem_ack ? ((redirect || count_d != 2'd2) ? ISSUE : FULL)
                                        : (redirect ? DRAIN : WAIT);
            DRAIN:   state_d = imem_ack ? ISSUE : DRAIN;
            FULL:    state_d = (pop || redirect) ? ISSUE : FULL;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, latched request address and registered request strobe
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= state_d == WAIT || state_d == DRAIN;
            if (state_q == ISSUE && !redirect) addr_q <= pc;
        end
    end

    // Two-entry circular queue; entries are never cleared, only count gates validity
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            count_q <= count_d;
            if (pop) rd_q <= ~rd_q;
            if (push) begin
                data_q[wr_idx] <= imem_rdata;
                pcs_q[wr_idx]  <= addr_q;
            end
        end
    end
endmodule

// File: tb/tb_subsystem_fetch.sv
// tb_subsystem_fetch: directed table, corner sequences and random traffic against a queue-based model
module tb_subsystem_fetch;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc = 16'd0;
    logic        redirect = 1'b0;
    logic        pc_enable;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [15:0] inst, inst_pc;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    subsystem_fetch #(.DATA_W(16), .ADDR_W(16)) dut (
        .CLK(CLK), .reset(reset), .pc(pc), .redirect(redirect), .pc_enable(pc_enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    // Reference model: queue of fetched PCs plus the request bookkeeping
    logic [15:0] mq[$];
    bit          live, drop, iss, boot;
    logic [15:0] maddr, pc_next, tgt_c;
    logic [15:0] saved_pc;

    typedef struct {
        int rdy, ack, req, addr, pen, val, ipc;
    } vec_t;
    vec_t tab[19];

    function automatic logic [15:0] mem(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset;
        mq.delete();
        live = 1'b0;
        drop = 1'b0;
        iss = 1'b0;
        boot = 1'b1;
        maddr = 16'd0;
    endtask

    task automatic cyc(input bit rdy, input bit ack, input bit rd, input logic [15:0] tgt);
        inst_ready = rdy;
        imem_ack = ack;
        redirect = rd;
        tgt_c = tgt;
        imem_rdata = mem(maddr);
        @(negedge CLK);
    endtask

    task automatic fin;
        bit acc, pen, val, pop, push;
        acc = live && imem_ack;
        pen = redirect || (acc && !drop);
        val = mq.size() != 0;
        chk("imem_req", 32'(imem_req), 32'(live));
        chk("imem_addr", 32'(imem_addr), 32'(maddr));
        chk("pc_enable", 32'(pc_enable), 32'(pen));
        chk("inst_valid", 32'(inst_valid), 32'(val));
        if (val) begin
            chk("inst_pc", 32'(inst_pc), 32'(mq[0]));
            chk("inst", 32'(inst), 32'(mem(mq[0])));
        end
        pop = val && inst_ready && !redirect;
        push = acc && !drop && !redirect;
        if (redirect) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                assert (mq.size() < 2) else $error("queue overflow at %0t", $time);
                mq.push_back(maddr);
            end
        end
        if (live) begin
            if (imem_ack) begin
                live = 1'b0;
                iss = mq.size() < 2;
            end else drop = drop || redirect;
        end else if (iss && !redirect) begin
            live = 1'b1;
            drop = 1'b0;
            maddr = pc;
            iss = 1'b0;
        end else iss = iss || boot || redirect || pop;
        boot = 1'b0;
        pc_next = pen ? (redirect ? tgt_c : pc + 16'd1) : pc;
        @(posedge CLK);
        #1;
        pc = pc_next;
    endtask

    task automatic step(input bit rdy, input bit ack, input bit rd, input logic [15:0] tgt);
        cyc(rdy, ack, rd, tgt);
        fin();
    endtask

    task automatic do_reset;
        reset = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_pen", 32'(pc_enable), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", 32'(inst), 32'd0);
        chk("rst_inst_pc", 32'(inst_pc), 32'd0);
        @(posedge CLK);
        #1 reset = 1'b1;
        model_reset();
    endtask

    initial begin
        tab = '{
            '{1, 1, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0}, '{1, 1, 1, 0, 1, 0, 0},
            '{1, 1, 0, 0, 0, 1, 0}, '{1, 1, 1, 1, 1, 0, 0}, '{1, 1, 0, 1, 0, 1, 1},
            '{1, 1, 1, 2, 1, 0, 0}, '{1, 1, 0, 2, 0, 1, 2}, '{1, 1, 1, 3, 1, 0, 0},
            '{0, 1, 0, 3, 0, 1, 3}, '{0, 1, 1, 4, 1, 1, 3}, '{0, 1, 0, 4, 0, 1, 3},
            '{0, 1, 0, 4, 0, 1, 3}, '{1, 0, 0, 4, 0, 1, 3}, '{0, 0, 0, 4, 0, 1, 4},
            '{0, 0, 1, 5, 0, 1, 4}, '{0, 0, 1, 5, 0, 1, 4}, '{0, 1, 1, 5, 1, 1, 4},
            '{0, 0, 0, 5, 0, 1, 4}
        };
        do_reset();
        for (int i = 0; i < 19; i++) begin
            cyc(tab[i].rdy != 0, tab[i].ack != 0, 1'b0, 16'd0);
            chk("tab_req", 32'(imem_req), 32'(tab[i].req));
            chk("tab_addr", 32'(imem_addr), 32'(tab[i].addr));
            chk("tab_pen", 32'(pc_enable), 32'(tab[i].pen));
            chk("tab_valid", 32'(inst_valid), 32'(tab[i].val));
            if (tab[i].val != 0) chk("tab_inst_pc", 32'(inst_pc), 32'(tab[i].ipc));
            fin();
            if (i == 8) chk("pc_after_4_acks", 32'(pc), 32'd4);
        end
        chk("pc_after_table", 32'(pc), 32'd6);

        // redirect while waiting: stale response drained without pc_enable
        do_reset();
        step(1'b1, 1'b0, 1'b1, 16'd5);
        step(1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0040);
        chk("drain_redirect_pen", 32'(pc_enable), 32'd1);
        fin();
        step(1'b1, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 1'b0, 16'd0);
        chk("drain_ack_pen", 32'(pc_enable), 32'd0);
        chk("drain_addr", 32'(imem_addr), 32'd5);
        chk("drain_req", 32'(imem_req), 32'd1);
        fin();
        step(1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 1'b0, 16'd0);
        chk("post_drain_addr", 32'(imem_addr), 32'h40);
        fin();
        cyc(1'b1, 1'b0, 1'b0, 16'd0);
        chk("post_drain_valid", 32'(inst_valid), 32'd1);
        chk("post_drain_inst_pc", 32'(inst_pc), 32'h40);
        fin();

        // redirect coinciding with an ack
        do_reset();
        step(1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0100);
        chk("redir_ack_pen", 32'(pc_enable), 32'd1);
        fin();
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        chk("redir_ack_pen_next", 32'(pc_enable), 32'd0);
        chk("redir_ack_valid", 32'(inst_valid), 32'd0);
        fin();
        cyc(1'b0, 1'b1, 1'b0, 16'd0);
        chk("redir_ack_addr", 32'(imem_addr), 32'h100);
        fin();

        // redirect coinciding with a pop while two entries are queued
        step(1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0200);
        chk("redir_pop_pen", 32'(pc_enable), 32'd1);
        fin();
        chk("redir_pop_valid", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 1'b0, 16'd0);
        chk("redir_pop_addr", 32'(imem_addr), 32'h200);
        fin();

        // asynchronous reset while waiting with one queued entry
        do_reset();
        step(1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b1, 1'b0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        chk("pre_areset_req", 32'(imem_req), 32'd1);
        chk("pre_areset_valid", 32'(inst_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("areset_req", 32'(imem_req), 32'd0);
        chk("areset_addr", 32'(imem_addr), 32'd0);
        chk("areset_valid", 32'(inst_valid), 32'd0);
        chk("areset_inst", 32'(inst), 32'd0);
        chk("areset_inst_pc", 32'(inst_pc), 32'd0);
        chk("areset_pen", 32'(pc_enable), 32'd0);
        @(posedge CLK);
        #1 reset = 1'b1;
        model_reset();
        saved_pc = pc;
        step(1'b0, 1'b1, 1'b0, 16'd0);
        step(1'b0, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        chk("post_areset_addr", 32'(imem_addr), 32'(saved_pc));
        chk("post_areset_req", 32'(imem_req), 32'd1);
        fin();

        // random traffic against the model
        do_reset();
        repeat (800) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 19) == 0, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/subsystem_fetch.md
Name: subsystem_fetch

Overview:
- Instruction fetch stage directly downstream of the PC adder subsystem; consumes `pc` and drives the PC register's `pc_enable`.
- Issues one instruction-memory request at a time and tolerates variable memory latency.
- Buffers fetched instructions, with their PCs, in a 2-entry queue feeding decode through a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the queue and discarding any in-flight response.

Parameters:
- DATA_W, 16, instruction width
- ADDR_W, 16, PC / instruction address width

Ports:
- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- pc  in  ADDR_W  current PC from PC adder subsystem
- redirect  in  1  execute has taken a branch/jump this cycle; pc_src already selects the target
- pc_enable  out  1  write enable to PC register
- imem_req  out  1  memory request, held until acknowledged
- imem_addr  out  ADDR_W  request address, stable while imem_req=1
- imem_ack  in  1  response valid this cycle (same cycle as req allowed)
- imem_rdata  in  DATA_W  instruction data, valid when imem_ack=1
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst  out  DATA_W  head instruction
- inst_pc  out  ADDR_W  PC of head instruction

Behaviour:
- Reset (reset=0, async): state=IDLE, queue count=0, entries=0, addr_q=0. Outputs imem_req=0, imem_addr=0, pc_enable=0, inst_valid=0, inst=0, inst_pc=0.
- States: IDLE, ISSUE, WAIT, DRAIN, FULL. imem_addr = addr_q always. imem_req=1 only in WAIT and DRAIN.
- IDLE: go to ISSUE next cycle.
- ISSUE: addr_q <= pc, go to WAIT. If redirect=1 this cycle, addr_q is not updated and the state stays ISSUE.
- WAIT, on imem_ack=1 and redirect=0:
  - push {imem_rdata, addr_q} to the queue tail; pc_enable=1 (PC advances to pc+1).
  - If post-push/pop count==2, go to FULL; else go to ISSUE.
- WAIT, on imem_ack=0: hold; imem_req and imem_addr remain stable.
- FULL: no request. Go to ISSUE in any cycle where a pop occurs.
- Redirect (any state):
  - Queue flushed (count=0, inst_valid=0 next cycle); pc_enable=1 that cycle so the PC loads the target; no pop occurs.
  - WAIT with imem_ack=0 goes to DRAIN; WAIT with imem_ack=1 drops the data and goes to ISSUE.
  - DRAIN stays DRAIN. IDLE, ISSUE, and FULL go to ISSUE.
- DRAIN: imem_req held at the stale addr_q until imem_ack. The response is discarded, pc_enable=0, then go to ISSUE. No new request is issued before the stale one completes.
- pc_enable timing: high only on a non-redirect ack in WAIT, or on redirect. Always a single-cycle pulse per event; never high in IDLE, ISSUE, DRAIN, or FULL except on redirect.
- Queue:
  - 2-entry FIFO, head at output. inst_valid = (count!=0).
  - Pop when inst_valid && inst_ready && !redirect.
  - Push and pop in the same cycle keep count unchanged and preserve ordering.
  - Overflow is impossible by construction: WAIT is entered only with count≤1. An assertion in the bench checks this.
  - Entries are not cleared on pop or flush; only inst_valid gates them.
- Latency: ack cycle → instruction visible at inst/inst_valid on the next cycle.
- Throughput: best case 1 instruction per 2 cycles (ISSUE + WAIT with same-cycle ack).
- Reset asserted mid-request: all state is cleared immediately. A later imem_ack while in IDLE or ISSUE is ignored.

Test Plan:
- Reset, then pc=0, imem_ack in the same cycle as every req, inst_ready=1 → requests to 0,1,2,3. inst/inst_pc pairs appear in order. pc_enable pulses once per ack and the PC reaches 4 after 4 acks.
- inst_ready=0 with immediate acks → two entries fill (pc 0,1) and the state goes to FULL. imem_req stays 0 and the PC stays at 2. Raising inst_ready for one cycle pops pc 0 → ISSUE → request to addr 2.
- Memory latency 3 cycles → imem_addr is stable across all req cycles. pc_enable is asserted only in the ack cycle.
- Redirect while WAIT at addr 5 with no ack, next pc=0x0040 → queue flushed, state DRAIN. The ack for addr 5 arrives 2 cycles later and its data is discarded with no pc_enable. The next request is to 0x0040 and the first delivered inst_pc is 0x0040.
- Redirect in the same cycle as an ack, and in the same cycle as a pop with count=2 → no push, no pop, count=0 next cycle. pc_enable=1 exactly one cycle and the next request goes to the target.
- reset driven low while WAIT with 1 queued entry → outputs go to 0 asynchronously, before the next CLK edge. After release, the first request is to the pc presented in ISSUE.
